// File: rtl/sequence_generator_pkg.sv
// Shared types and default parameter values for the serial sequence generator.
package sequence_generator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAP  = 2'b10,
    DONE = 2'b11
  } state_e;

  localparam int unsigned PAT_W_DEF = 4;
  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned GAP_DEF   = 2;

endpackage

// File: rtl/seq_shift_reg.sv
// Parallel-load, MSB-first shift register holding the pattern being sent.
module seq_shift_reg
  import sequence_generator_pkg::*;
#(
  parameter int unsigned W = PAT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         msb_o,
  output logic         next_o
);

  logic [W-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= data_i;
    end else if (shift_i) begin
      sr_q <= {sr_q[W-2:0], 1'b0};
    end
  end

  assign msb_o  = sr_q[W-1];
  assign next_o = sr_q[W-2];

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern generator: sends a latched pattern MSB first, repeated with
// idle gaps, under ready/valid flow control, then pulses done.
module sequence_generator
  import sequence_generator_pkg::state_e,
         sequence_generator_pkg::IDLE,
         sequence_generator_pkg::SEND,
         sequence_generator_pkg::DONE;
#(
  parameter int unsigned PAT_W = sequence_generator_pkg::PAT_W_DEF,
  parameter int unsigned CNT_W = sequence_generator_pkg::CNT_W_DEF,
  parameter int unsigned GAP   = sequence_generator_pkg::GAP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  input  logic             gap_bit,
  input  logic             ready,
  output logic             o,
  output logic             o_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      IDX_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(PAT_W - 1);
  localparam logic [3:0]       GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : '0;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [3:0]       gap_q, gap_d;
  logic [PAT_W-1:0] pat_q, pat_d;

  logic             sr_load, sr_shift, sr_msb, sr_next, msb_d;
  logic [PAT_W-1:0] sr_load_val;

  logic o_q, o_d, o_valid_q, o_valid_d, busy_q, busy_d, done_q, done_d;

  seq_shift_reg #(.W(PAT_W)) u_shift (
    .clk     (clk),
    .rst     (rst),
    .load_i  (sr_load),
    .shift_i (sr_shift),
    .data_i  (sr_load_val),
    .msb_o   (sr_msb),
    .next_o  (sr_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      pat_q   <= pat_d;
    end
  end

  // The GAP state literal is package-qualified: the GAP parameter owns the bare name here.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rep_d       = rep_q;
    gap_d       = gap_q;
    pat_d       = pat_q;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    sr_load_val = pat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = SEND;
          pat_d       = pattern;
          rep_d       = (reps == '0) ? CNT_W'(1) : reps;
          idx_d       = IDX_TOP;
          sr_load     = 1'b1;
          sr_load_val = pattern;
        end
      end
      SEND: begin
        if (ready) begin
          if (idx_q != '0) begin
            idx_d    = idx_q - 1'b1;
            sr_shift = 1'b1;
          end else if (rep_q > CNT_W'(1)) begin
            rep_d = rep_q - 1'b1;
            if (GAP > 0) begin
              state_d = sequence_generator_pkg::GAP;
              gap_d   = GAP_LAST;
            end else begin
              idx_d   = IDX_TOP;
              sr_load = 1'b1;
            end
          end else begin
            state_d = DONE;
          end
        end
      end
      sequence_generator_pkg::GAP: begin
        if (gap_q == '0) begin
          state_d = SEND;
          idx_d   = IDX_TOP;
          sr_load = 1'b1;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state.
  always_comb begin
    msb_d = sr_msb;
    if (sr_load) begin
      msb_d = sr_load_val[PAT_W-1];
    end else if (sr_shift) begin
      msb_d = sr_next;
    end
    o_valid_d = (state_d == SEND);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    case (state_d)
      SEND:                        o_d = msb_d;
      sequence_generator_pkg::GAP: o_d = gap_bit;
      default:                     o_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_q       <= 1'b0;
      o_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o       = o_q;
  assign o_valid = o_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: two instances (GAP=2 and GAP=0) against a token-queue model.
module tb_sequence_generator;

  localparam int unsigned PW = 4;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst, start, ready, gap_bit;
  logic [PW-1:0] pattern;
  logic [CW-1:0] reps;
  logic          o0, v0, b0, d0, o1, v1, b1, d1;

  sequence_generator #(.PAT_W(PW), .CNT_W(CW), .GAP(2)) dut0 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .reps(reps),
    .gap_bit(gap_bit), .ready(ready), .o(o0), .o_valid(v0), .busy(b0), .done(d0)
  );

  sequence_generator #(.PAT_W(PW), .CNT_W(CW), .GAP(0)) dut1 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .reps(reps),
    .gap_bit(gap_bit), .ready(ready), .o(o1), .o_valid(v1), .busy(b1), .done(d1)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  // Per-instance stream of pending tokens: 0/1 data bit, 2 gap cycle, 3 done cycle.
  int   mq [2][$];
  logic prev_gb = 1'b0;

  typedef struct {
    logic          rst, start, ready, gap_bit;
    logic [PW-1:0] pattern;
    logic [CW-1:0] reps;
    logic          ev, eo, eb, ed;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int glen(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic build(input int k);
    int n;
    n = (reps == '0) ? 1 : int'(reps);
    for (int r = 0; r < n; r++) begin
      for (int i = PW - 1; i >= 0; i--) mq[k].push_back(int'(pattern[i]));
      if (r < n - 1) for (int g = 0; g < glen(k); g++) mq[k].push_back(2);
    end
    mq[k].push_back(3);
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mq[k].delete();
      end else if (mq[k].size() == 0) begin
        if (start) build(k);
      end else if (mq[k][0] >= 2 || ready) begin
        void'(mq[k].pop_front());
      end
    end
    prev_gb = gap_bit;
  endtask

  task automatic check_all();
    logic eo, ev, eb, ed;
    int   t;
    for (int k = 0; k < 2; k++) begin
      eo = 1'b0; ev = 1'b0; eb = 1'b0; ed = 1'b0;
      if (mq[k].size() != 0) begin
        t  = mq[k][0];
        eb = 1'b1;
        if (t <= 1) begin
          ev = 1'b1;
          eo = t[0];
        end else if (t == 2) begin
          eo = prev_gb;
        end else begin
          ed = 1'b1;
        end
      end
      chk($sformatf("dut%0d.o", k),       (k == 0) ? o0 : o1, eo);
      chk($sformatf("dut%0d.o_valid", k), (k == 0) ? v0 : v1, ev);
      chk($sformatf("dut%0d.busy", k),    (k == 0) ? b0 : b1, eb);
      chk($sformatf("dut%0d.done", k),    (k == 0) ? d0 : d1, ed);
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    start = 1'b0;
    rst   = 1'b0;
    ready = 1'b1;
    while ((b0 || b1) && n < 3000) begin
      cycle();
      n++;
    end
    chk("idle_timeout", {31'd0, (b0 || b1)}, 0);
  endtask

  task automatic run_count(input logic [PW-1:0] p, input logic [CW-1:0] r, output int n);
    pattern = p;
    reps    = r;
    start   = 1'b1;
    cycle();
    start = 1'b0;
    n = 0;
    while (b0 && n < 3000) begin
      n++;
      cycle();
    end
  endtask

  initial begin
    int          n;
    logic [11:0] exp12;

    rst = 1'b1; start = 1'b1; ready = 1'b1; gap_bit = 1'b0;
    pattern = 4'b1111; reps = 8'd1;
    cycle();
    cycle();
    chk("rst_o", o0, 0);
    chk("rst_valid", v0, 0);
    chk("rst_busy", b0, 0);
    chk("rst_done", d0, 0);
    rst = 1'b0; start = 1'b0;
    cycle();

    // Single repetition of 1101, ready always high.
    vecs[0] = '{rst:0, start:1, ready:1, gap_bit:0, pattern:4'b1101, reps:8'd1, ev:1, eo:1, eb:1, ed:0};
    vecs[1] = '{rst:0, start:0, ready:1, gap_bit:0, pattern:4'b1101, reps:8'd1, ev:1, eo:1, eb:1, ed:0};
    vecs[2] = '{rst:0, start:0, ready:1, gap_bit:0, pattern:4'b1101, reps:8'd1, ev:1, eo:0, eb:1, ed:0};
    vecs[3] = '{rst:0, start:0, ready:1, gap_bit:0, pattern:4'b1101, reps:8'd1, ev:1, eo:1, eb:1, ed:0};
    vecs[4] = '{rst:0, start:0, ready:1, gap_bit:0, pattern:4'b1101, reps:8'd1, ev:0, eo:0, eb:1, ed:1};
    vecs[5] = '{rst:0, start:0, ready:1, gap_bit:0, pattern:4'b1101, reps:8'd1, ev:0, eo:0, eb:0, ed:0};
    for (int i = 0; i < 6; i++) begin
      rst = vecs[i].rst; start = vecs[i].start; ready = vecs[i].ready;
      gap_bit = vecs[i].gap_bit; pattern = vecs[i].pattern; reps = vecs[i].reps;
      cycle();
      chk($sformatf("vec%0d.o_valid", i), v0, vecs[i].ev);
      chk($sformatf("vec%0d.o", i),       o0, vecs[i].eo);
      chk($sformatf("vec%0d.busy", i),    b0, vecs[i].eb);
      chk($sformatf("vec%0d.done", i),    d0, vecs[i].ed);
    end

    // Two repetitions with gap: 4 + 2 + 4 + 1 busy cycles.
    wait_idle();
    gap_bit = 1'b0;
    run_count(4'b1101, 8'd2, n);
    chk("busy_reps2", n, 11);

    // Stall for three cycles while bit 2 of 1001 is presented.
    wait_idle();
    pattern = 4'b1001; reps = 8'd1; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_o", o0, 0);
      chk("stall_valid", v0, 1);
      cycle();
    end
    chk("stall_o_end", o0, 0);
    ready = 1'b1;
    wait_idle();

    // GAP=0 instance: 12 back-to-back valid bits, then done.
    pattern = 4'b1010; reps = 8'd3; start = 1'b1;
    cycle();
    start = 1'b0;
    exp12 = 12'b101010101010;
    for (int i = 0; i < 12; i++) begin
      chk("nogap_valid", v1, 1);
      chk("nogap_o", o1, exp12[11-i]);
      cycle();
    end
    chk("nogap_done", d1, 1);

    // Reset in the middle of the first repetition.
    wait_idle();
    pattern = 4'b1101; reps = 8'd3; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    chk("mid_bit2", o0, 1);
    rst = 1'b1;
    cycle();
    chk("abort_valid", v0, 0);
    chk("abort_busy", b0, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("abort_nodone", d0, 0);
    end
    pattern = 4'b1011; reps = 8'd1; start = 1'b1;
    cycle();
    start = 1'b0;
    chk("restart_msb", o0, 1);
    chk("restart_valid", v0, 1);
    cycle();
    chk("restart_bit2", o0, 0);

    // Start pulses during SEND and during DONE are dropped.
    wait_idle();
    pattern = 4'b1101; reps = 8'd1; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    pattern = 4'b0000; reps = 8'd5; start = 1'b1;
    cycle();
    start = 1'b0;
    n = 0;
    while (!d0 && n < 20) begin
      cycle();
      n++;
    end
    chk("reach_done", d0, 1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("done_start_ignored", b0, 0);
    cycle();
    chk("no_queued_start", b0, 0);

    // reps=0 behaves like reps=1.
    wait_idle();
    run_count(4'b1101, 8'd0, n);
    chk("busy_reps0", n, 5);

    // Maximum repeat count: 255*4 + 254*2 + 1 busy cycles.
    wait_idle();
    gap_bit = 1'b1;
    run_count(4'b0110, 8'hFF, n);
    chk("busy_repsmax", n, 1529);

    // Randomized traffic against the model.
    wait_idle();
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      start   = ($urandom_range(0, 3) == 0);
      pattern = PW'($urandom);
      reps    = CW'($urandom_range(0, 3));
      ready   = ($urandom_range(0, 3) != 0);
      gap_bit = 1'($urandom);
      cycle();
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter CNT_W, default 8: width of the repeat count.
REQ-003 Parameter GAP, default 2: idle cycles between repetitions, legal range 0..15.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  request a transmission; sampled only in IDLE.
REQ-007 pattern  in  PAT_W  bit pattern to send, MSB first; latched on an accepted start.
REQ-008 reps  in  CNT_W  number of pattern repetitions; latched on an accepted start; 0 is treated as 1.
REQ-009 gap_bit  in  1  level driven on o during GAP; sampled every GAP cycle.
REQ-010 ready  in  1  consumer accepts the current bit when ready and o_valid are both 1.
REQ-011 o  out  1  serial data bit, registered.
REQ-012 o_valid  out  1  o carries a pattern bit, registered.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  single-cycle pulse after the final bit of the final repetition is accepted.

Function
REQ-015 The FSM shall have four states, IDLE, SEND, GAP and DONE, and no others.
REQ-016 IDLE: start=1 at edge k shall latch pattern and reps, load bit index PAT_W-1, and enter SEND with o_valid=1 and o=pattern[PAT_W-1] visible after edge k.
REQ-017 SEND shall hold o and o_valid stable while ready=0; data and valid shall not change without acceptance.
REQ-018 SEND: each accepted bit shall decrement the index and present the next lower pattern bit on the following cycle.
REQ-019 SEND: acceptance of bit 0 with repetitions remaining and GAP>0 shall enter GAP.
REQ-020 SEND: acceptance of bit 0 with repetitions remaining and GAP=0 shall reload index PAT_W-1 and stay in SEND, with no bubble in o_valid.
REQ-021 SEND: acceptance of bit 0 of the final repetition shall enter DONE.
REQ-022 GAP shall drive o_valid=0 and o=gap_bit for exactly GAP cycles, counted regardless of ready, then return to SEND at index PAT_W-1.
REQ-023 DONE shall last exactly one cycle with done=1, o_valid=0 and busy=1, then enter IDLE.
REQ-024 In IDLE, o shall be 0 and o_valid, busy and done shall be 0.
REQ-025 A start asserted outside IDLE, including during DONE, shall be ignored and not queued.
REQ-026 Changes on pattern or reps after an accepted start shall have no effect until the next accepted start.
REQ-027 The repetition counter shall be CNT_W bits wide and count down to 1; reps at its maximum value shall produce exactly 2^CNT_W-1 repetitions, with no wrap-around.

Reset
REQ-028 rst=1 at any edge shall force IDLE, clear the index, repetition and gap counters, and set o, o_valid, busy and done to 0 after that edge.
REQ-029 rst shall take priority over start and ready in the same cycle.
REQ-030 Reset during a transmission shall abort it without asserting done.

Structure
REQ-031 Package sequence_generator_pkg shall hold the state enum typedef (IDLE=2'b00, SEND=2'b01, GAP=2'b10, DONE=2'b11) and the default parameter constants.
REQ-032 The pattern shall be held in sub-module seq_shift_reg: a parallel-load, MSB-out shift register with load and shift-enable inputs, reset by the same sync rst.
REQ-033 The FSM shall use one registered-state block and one combinational next-state block with a default assignment; no latches.

Verification
REQ-034 PAT_W=4, GAP=2, pattern=1101, reps=1, ready tied 1: start at cycle 0 -> o_valid for cycles 1-4 with o=1,1,0,1; done=1 at cycle 5; busy=0 at cycle 6.
REQ-035 Same settings with reps=2, gap_bit=0: 1101, then two cycles with o_valid=0 and o=0, then 1101, then done; total busy time 11 cycles.
REQ-036 pattern=1001, ready low for 3 cycles while bit 2 is presented: o=0 and o_valid=1 held throughout; the output sequence is still 1,0,0,1.
REQ-037 GAP=0, reps=3, pattern=1010: 12 consecutive valid bits 101010101010 with no bubble, then a done pulse.
REQ-038 rst asserted during bit 2 of the first repetition: all outputs 0 on the next cycle, no done; a following start transmits cleanly from the MSB.
REQ-039 start pulsed during SEND and during DONE: ignored; reps=0 behaves exactly like reps=1.
